// File: rtl/pulse_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulse_sched_pkg
// Description : Shared types and constants for the pulse scheduler.
//               state_t : scheduler FSM states (IDLE, SPACE)
//               GAP_W   : width of the inter-pulse gap counter
// Revision    : 1.0 - initial release
// ============================================================================
package pulse_sched_pkg;

  localparam int GAP_W = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SPACE = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/evt_chan.sv
`default_nettype none
// ============================================================================
// Module      : evt_chan
// Description : One scheduler channel. Turns a synchronous level into
//               rising-edge events and keeps a saturating count of events
//               not yet granted, plus a sticky overflow flag.
// Ports       : clk      in  clock, rising edge
//               rst_n    in  synchronous active-low reset
//               lvl      in  channel level input
//               grant    in  this channel is being served this cycle
//               ovf_clr  in  clear the overflow flag
//               nonzero  out pending count is non-zero
//               ovf      out sticky overflow flag
// Revision    : 1.0 - initial release
// ============================================================================
module evt_chan
  import pulse_sched_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic lvl,
  input  logic grant,
  input  logic ovf_clr,
  output logic nonzero,
  output logic ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             prev;
  logic [CNT_W-1:0] cnt;
  logic             rise;
  logic             ovf_set;

  assign rise    = lvl & ~prev;
  // Only an ungranted edge can push the counter past its maximum.
  assign ovf_set = rise & ~grant & (cnt == CNT_MAX);
  assign nonzero = |cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev <= 1'b0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else begin
      prev <= lvl;
      // A simultaneous edge and grant cancel each other out.
      if (rise && !grant) begin
        if (cnt != CNT_MAX) begin
          cnt <= cnt + 1'b1;
        end
      end else if (grant && !rise) begin
        cnt <= cnt - 1'b1;
      end
      // Clear takes precedence over a same-cycle overflow.
      ovf <= ovf_clr ? 1'b0 : (ovf | ovf_set);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pulse_sched.sv
`default_nettype none
// ============================================================================
// Module      : pulse_sched
// Description : Multi-channel event scheduler. Counts rising edges per
//               channel and serializes them round-robin onto a single
//               one-cycle pulse with at least GAP idle cycles in between.
// Ports       : CLK       in  clock, rising edge
//               RST       in  synchronous active-low reset
//               LVL_SIG   in  per-channel level inputs
//               EN        in  grant enable (counting continues when low)
//               OVF_CLR   in  clear all overflow flags
//               PULSE_SIG out registered one-cycle event pulse
//               CH_ID     out channel served by the latest pulse
//               PEND_ANY  out any channel has pending events
//               OVF       out sticky per-channel overflow flags
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_sched
  import pulse_sched_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 3,
  parameter int GAP    = 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NUM_CH-1:0]         LVL_SIG,
  input  logic                      EN,
  input  logic                      OVF_CLR,
  output logic                      PULSE_SIG,
  output logic [$clog2(NUM_CH)-1:0] CH_ID,
  output logic                      PEND_ANY,
  output logic [NUM_CH-1:0]         OVF
);

  localparam int               CH_W     = $clog2(NUM_CH);
  localparam logic [GAP_W-1:0] GAP_L    = GAP_W'(GAP);
  localparam logic [CH_W-1:0]  LAST_RST = CH_W'(NUM_CH - 1);

  state_t              state, state_nx;
  logic [GAP_W-1:0]    gcnt, gcnt_nx;
  logic [CH_W-1:0]     last;
  logic [CH_W-1:0]     winner;
  logic                found;
  logic                do_grant;
  logic [NUM_CH-1:0]   nonzero;
  logic [NUM_CH-1:0]   grant;

  // Per-channel edge detection and pending counters.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    evt_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk     (CLK),
      .rst_n   (RST),
      .lvl     (LVL_SIG[i]),
      .grant   (grant[i]),
      .ovf_clr (OVF_CLR),
      .nonzero (nonzero[i]),
      .ovf     (OVF[i])
    );
  end

  assign PEND_ANY = |nonzero;

  // Round-robin search starting just after the last served channel; the
  // last candidate examined is the last served channel itself.
  always_comb begin : p_arb
    int sum;
    logic [CH_W-1:0] idx;
    sum    = 0;
    idx    = '0;
    winner = '0;
    found  = 1'b0;
    for (int off = 1; off <= NUM_CH; off++) begin
      sum = int'(last) + off;
      if (sum >= NUM_CH) begin
        sum = sum - NUM_CH;
      end
      idx = CH_W'(sum);
      if (!found && nonzero[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign do_grant = (state == IDLE) && EN && found;
  assign grant    = do_grant ? (NUM_CH'(1) << winner) : '0;

  always_comb begin : p_fsm
    state_nx = state;
    gcnt_nx  = gcnt;
    case (state)
      IDLE: begin
        // With no gap configured the FSM never leaves IDLE.
        if (do_grant && (GAP_L != '0)) begin
          state_nx = SPACE;
          gcnt_nx  = GAP_L;
        end
      end
      SPACE: begin
        gcnt_nx = gcnt - 1'b1;
        if (gcnt == GAP_W'(1)) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= IDLE;
      gcnt      <= '0;
      last      <= LAST_RST;
      PULSE_SIG <= 1'b0;
      CH_ID     <= '0;
    end else begin
      state     <= state_nx;
      gcnt      <= gcnt_nx;
      PULSE_SIG <= do_grant;
      if (do_grant) begin
        CH_ID <= winner;
        last  <= winner;
      end
    end
  end

endmodule
`default_nettype wire
